// File: rtl/ttt_turn_ctrl.sv
// ttt_turn_ctrl: debounced keypad move sequencer, board owner and win/draw judge for tic-tac-toe.
// Stone and move_ok land 2 clocks after key acceptance, turn/result 3 clocks after; optional forfeit timer via TTT_TIMEOUT_EN.
module ttt_turn_ctrl #(
   parameter int STABLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 25_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [3:0]  key_data,
   output logic [17:0] board,
   output logic        turn_o,
   output logic [1:0]  result,
   output logic        game_active,
   output logic        move_ok,
   output logic        move_err
);
   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_KEY, S_CHECK, S_COMMIT, S_EVAL, S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [17:0] board_q, board_d;
   logic        turn_q, turn_d;
   logic [1:0]  result_q, result_d;
   logic        game_active_q, game_active_d;
   logic        move_ok_q, move_ok_d;
   logic        move_err_q, move_err_d;
   logic [3:0]  cell_q, cell_d;
   logic [3:0]  move_cnt_q, move_cnt_d;
   logic [3:0]  prev_q, prev_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic        armed_q, armed_d;

   logic [3:0]  code;
   logic [CW-1:0] stable_now;
   logic        held, accept, new_game, active, timeout;
   logic        cell_occ, win;
   logic [17:0] commit_mask;
   logic [8:0]  plane;

   // Codes 10-15 behave exactly like "no key" for both debounce and arming.
   assign code       = (key_data > 4'd9) ? 4'd0 : key_data;
   assign stable_now = (code != prev_q)       ? CW'(1) :
                       (cnt_q == STABLE_MAX)  ? cnt_q  : cnt_q + CW'(1);
   assign held       = (stable_now == STABLE_MAX);
   assign active     = state_q inside {S_WAIT_KEY, S_CHECK, S_COMMIT, S_EVAL};
   assign new_game   = start && (state_q inside {S_IDLE, S_WAIT_KEY, S_DONE});
   assign accept     = (state_q == S_WAIT_KEY) && armed_q && (code != 4'd0) && held;

`ifdef TTT_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] timer_q, timer_d;
   assign timeout = (state_q == S_WAIT_KEY) && ((timer_q + TW'(1)) == TW'(TIMEOUT_CYCLES));
`else
   assign timeout = (TIMEOUT_CYCLES < 0);
`endif

   always_comb begin
      cell_occ    = 1'b0;
      commit_mask = '0;
      for (int k = 1; k <= 9; k++) begin
         if (cell_q == 4'(k)) begin
            cell_occ             = |board_q[18-2*k +: 2];
            commit_mask[18-2*k]  = ~turn_q;
            commit_mask[19-2*k]  = turn_q;
         end
      end
      for (int k = 0; k < 9; k++) begin
         plane[k] = turn_q ? board_q[17-2*k] : board_q[16-2*k];
      end
      win = (&plane[2:0]) | (&plane[5:3]) | (&plane[8:6]) |
            (plane[0] & plane[3] & plane[6]) | (plane[1] & plane[4] & plane[7]) |
            (plane[2] & plane[5] & plane[8]) | (plane[0] & plane[4] & plane[8]) |
            (plane[2] & plane[4] & plane[6]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         board_q       <= '0;
         turn_q        <= 1'b0;
         result_q      <= 2'b00;
         game_active_q <= 1'b0;
         move_ok_q     <= 1'b0;
         move_err_q    <= 1'b0;
         cell_q        <= '0;
         move_cnt_q    <= '0;
         prev_q        <= '0;
         cnt_q         <= '0;
         armed_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         board_q       <= board_d;
         turn_q        <= turn_d;
         result_q      <= result_d;
         game_active_q <= game_active_d;
         move_ok_q     <= move_ok_d;
         move_err_q    <= move_err_d;
         cell_q        <= cell_d;
         move_cnt_q    <= move_cnt_d;
         prev_q        <= prev_d;
         cnt_q         <= cnt_d;
         armed_q       <= armed_d;
      end
   end

`ifdef TTT_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) timer_q <= '0;
      else     timer_q <= timer_d;
   end
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     if (start) state_d = S_WAIT_KEY;
         S_WAIT_KEY: begin
            if (!start) begin
               if (accept)       state_d = S_CHECK;
               else if (timeout) state_d = S_DONE;
            end
         end
         S_CHECK:    state_d = cell_occ ? S_WAIT_KEY : S_COMMIT;
         S_COMMIT:   state_d = S_EVAL;
         S_EVAL:     state_d = (win || move_cnt_q == 4'd9) ? S_DONE : S_WAIT_KEY;
         S_DONE:     if (start) state_d = S_WAIT_KEY;
         default:    state_d = S_IDLE;
      endcase
   end

   always_comb begin
      board_d       = board_q;
      turn_d        = turn_q;
      result_d      = result_q;
      move_ok_d     = 1'b0;
      move_err_d    = 1'b0;
      cell_d        = cell_q;
      move_cnt_d    = move_cnt_q;
      prev_d        = prev_q;
      cnt_d         = cnt_q;
      armed_d       = armed_q;
      game_active_d = state_d inside {S_WAIT_KEY, S_CHECK, S_COMMIT, S_EVAL};
`ifdef TTT_TIMEOUT_EN
      timer_d       = timer_q;
`endif
      if (new_game) begin
         board_d    = '0;
         turn_d     = 1'b0;
         result_d   = 2'b00;
         move_cnt_d = '0;
         prev_d     = '0;
         cnt_d      = '0;
         armed_d    = 1'b0;
`ifdef TTT_TIMEOUT_EN
         timer_d    = '0;
`endif
      end else begin
         // Debounce keeps running through CHECK..EVAL so a release during a move still re-arms.
         if (active) begin
            prev_d = code;
            cnt_d  = stable_now;
            if (code == 4'd0 && held) armed_d = 1'b1;
         end
         case (state_q)
            S_WAIT_KEY: begin
               if (accept) begin
                  cell_d  = code;
                  armed_d = 1'b0;
               end else begin
`ifdef TTT_TIMEOUT_EN
                  timer_d = timer_q + TW'(1);
`endif
                  if (timeout) result_d = turn_q ? 2'b01 : 2'b10;
               end
            end
            S_CHECK:  if (cell_occ) move_err_d = 1'b1;
            S_COMMIT: begin
               board_d    = board_q | commit_mask;
               move_cnt_d = move_cnt_q + 4'd1;
               move_ok_d  = 1'b1;
`ifdef TTT_TIMEOUT_EN
               timer_d    = '0;
`endif
            end
            S_EVAL: begin
               if (win)                      result_d = turn_q ? 2'b10 : 2'b01;
               else if (move_cnt_q == 4'd9)  result_d = 2'b11;
               else                          turn_d   = ~turn_q;
            end
            default: ;
         endcase
      end
   end

   assign board       = board_q;
   assign turn_o      = turn_q;
   assign result      = result_q;
   assign game_active = game_active_q;
   assign move_ok     = move_ok_q;
   assign move_err    = move_err_q;
endmodule
